// File: rtl/fft_pkg.sv
// fft_pkg: shared types, state encoding, bit reversal and twiddle table generation for the iterative FFT
package fft_pkg;
    localparam int CPLX_WIDTH = 12;
    typedef struct packed {
        logic signed [CPLX_WIDTH-1:0] re;
        logic signed [CPLX_WIDTH-1:0] im;
    } complex_t;
    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
    function automatic logic [9:0] bitrev(input logic [9:0] idx, input int log2n);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < log2n; i++) r[i] = idx[log2n-1-i];
        return r;
    endfunction
    function automatic int twiddle(input int k, input int n, input int tw_width, input bit sine);
        real ang, v;
        ang = 6.283185307179586 * k / n;
        v = (sine ? $sin(ang) : $cos(ang)) * (2.0 ** (tw_width - 1) - 1.0);
        return v < 0.0 ? -$rtoi(0.5 - v) : $rtoi(v + 0.5);
    endfunction
endpackage

// File: rtl/fft_bfly_core.sv
// fft_bfly_core: registered radix-2 butterfly (a,b,w,scale -> ya=a+b*w, yb=a-b*w, sat), rounded twiddle product, optional >>>1, saturating
module fft_bfly_core #(
    parameter int WIDTH = 12,
    parameter int TW_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [WIDTH-1:0]    a_re,
    input  logic signed [WIDTH-1:0]    a_im,
    input  logic signed [WIDTH-1:0]    b_re,
    input  logic signed [WIDTH-1:0]    b_im,
    input  logic signed [TW_WIDTH-1:0] w_re,
    input  logic signed [TW_WIDTH-1:0] w_im,
    input  logic                       scale,
    output logic signed [WIDTH-1:0]    ya_re,
    output logic signed [WIDTH-1:0]    ya_im,
    output logic signed [WIDTH-1:0]    yb_re,
    output logic signed [WIDTH-1:0]    yb_im,
    output logic                       sat
);
    localparam int PW = WIDTH + TW_WIDTH + 1;
    localparam int EW = WIDTH + 2;
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_WIDTH - 2);
    localparam logic signed [EW-1:0] MAXV = EW'((1 <<< (WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] MINV = -MAXV - EW'(1);
    logic signed [PW-1:0] pr, pi;
    logic signed [EW-1:0] tr, ti, s0, s1, s2, s3;
    function automatic logic signed [EW-1:0] post(input logic signed [EW-1:0] v, input logic sc);
        return sc ? v >>> 1 : v;
    endfunction
    function automatic logic signed [WIDTH-1:0] clip(input logic signed [EW-1:0] v);
        return v > MAXV ? MAXV[WIDTH-1:0] : v < MINV ? MINV[WIDTH-1:0] : v[WIDTH-1:0];
    endfunction
    function automatic logic ovr(input logic signed [EW-1:0] v);
        return v > MAXV || v < MINV;
    endfunction
    always_comb begin
        pr = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
        pi = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
        tr = EW'((pr + RND) >>> (TW_WIDTH - 1));
        ti = EW'((pi + RND) >>> (TW_WIDTH - 1));
        s0 = post(EW'(a_re) + tr, scale);
        s1 = post(EW'(a_im) + ti, scale);
        s2 = post(EW'(a_re) - tr, scale);
        s3 = post(EW'(a_im) - ti, scale);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ya_re <= '0;
            ya_im <= '0;
            yb_re <= '0;
            yb_im <= '0;
            sat <= 1'b0;
        end else begin
            ya_re <= clip(s0);
            ya_im <= clip(s1);
            yb_re <= clip(s2);
            yb_im <= clip(s3);
            sat <= ovr(s0) | ovr(s1) | ovr(s2) | ovr(s3);
        end
    end
endmodule

// File: rtl/fft_iterative.sv
// fft_iterative: in-place radix-2 DIT FFT/IFFT; in_* streams N samples in, out_* streams N bins out with index/last, busy and sticky ovf status
module fft_iterative
    import fft_pkg::*;
#(
    parameter int N = 16,
    parameter int WIDTH = 12,
    parameter int TW_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WIDTH-1:0]  in_re,
    input  logic signed [WIDTH-1:0]  in_im,
    input  logic                     mode_inv,
    input  logic                     mode_scale,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [WIDTH-1:0]  out_re,
    output logic signed [WIDTH-1:0]  out_im,
    output logic [$clog2(N)-1:0]     out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     ovf
);
    localparam int LOG2N = $clog2(N);
    localparam int HALF = N / 2;
    localparam int TWB = LOG2N - 1;
    typedef logic [LOG2N-1:0] addr_t;
    state_t state, state_nx;
    addr_t cnt, bcnt, jx, hmask, ia, ib, p1_a, p1_b, p2_a, p2_b;
    logic [TWB-1:0] itw, p1_tw;
    logic [3:0] stage, tsh;
    logic inv_r, scale_r, p1_v, p2_v, issue, stage_end, last_stage, acc, out_hs;
    logic [2*WIDTH-1:0] mem [N];
    logic [2*WIDTH-1:0] rd_a, rd_b;
    logic signed [TW_WIDTH-1:0] rom_cos [HALF];
    logic signed [TW_WIDTH-1:0] rom_sin [HALF];
    logic signed [TW_WIDTH-1:0] w_re, w_im;
    logic signed [WIDTH-1:0] ya_re, ya_im, yb_re, yb_im;
    logic bf_sat;
    for (genvar i = 0; i < HALF; i++) begin : g_tw
        assign rom_cos[i] = TW_WIDTH'(twiddle(i, N, TW_WIDTH, 1'b0));
        assign rom_sin[i] = TW_WIDTH'(twiddle(i, N, TW_WIDTH, 1'b1));
    end
    // butterfly j of stage s: a = j with a zero inserted at bit s, b = a + 2^s, twiddle k<<(log2N-1-s)
    always_comb begin
        jx = addr_t'(bcnt[LOG2N-2:0]);
        hmask = (addr_t'(1) << stage) - addr_t'(1);
        ia = ((jx >> stage) << (stage + 4'd1)) | (jx & hmask);
        ib = ia | (addr_t'(1) << stage);
        tsh = 4'(TWB) - stage;
        itw = TWB'((jx & hmask) << tsh);
        issue = state == COMPUTE && bcnt < addr_t'(HALF);
        stage_end = state == COMPUTE && bcnt == addr_t'(HALF + 1);
        last_stage = stage == 4'(LOG2N - 1);
        in_ready = state == LOAD && !rst;
        acc = in_valid && in_ready;
        out_hs = out_valid && out_ready;
        busy = state != LOAD;
        w_re = rom_cos[p1_tw];
        w_im = inv_r ? rom_sin[p1_tw] : -rom_sin[p1_tw];
        state_nx = acc && cnt == addr_t'(N - 1) ? COMPUTE :
                   stage_end && last_stage ? UNLOAD :
                   state == UNLOAD && out_hs && out_last ? LOAD : state;
    end
    fft_bfly_core #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) u_bfly (
        .clk(clk),
        .rst(rst),
        .a_re(rd_a[2*WIDTH-1:WIDTH]),
        .a_im(rd_a[WIDTH-1:0]),
        .b_re(rd_b[2*WIDTH-1:WIDTH]),
        .b_im(rd_b[WIDTH-1:0]),
        .w_re(w_re),
        .w_im(w_im),
        .scale(scale_r),
        .ya_re(ya_re),
        .ya_im(ya_im),
        .yb_re(yb_re),
        .yb_im(yb_im),
        .sat(bf_sat)
    );
    // read, register, write: the butterfly result lands two cycles after its addresses were issued
    always_ff @(posedge clk) begin
        rd_a <= mem[ia];
        rd_b <= mem[ib];
        p1_a <= ia;
        p1_b <= ib;
        p1_tw <= itw;
        p2_a <= p1_a;
        p2_b <= p1_b;
        if (acc) mem[addr_t'(bitrev(10'(cnt), LOG2N))] <= {in_re, in_im};
        if (p2_v) begin
            mem[p2_a] <= {ya_re, ya_im};
            mem[p2_b] <= {yb_re, yb_im};
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt <= '0;
            bcnt <= '0;
            stage <= '0;
            inv_r <= 1'b0;
            scale_r <= 1'b0;
            p1_v <= 1'b0;
            p2_v <= 1'b0;
            ovf <= 1'b0;
            out_valid <= 1'b0;
            out_re <= '0;
            out_im <= '0;
            out_index <= '0;
            out_last <= 1'b0;
        end else begin
            state <= state_nx;
            bcnt <= stage_end || state != COMPUTE ? '0 : bcnt + addr_t'(1);
            p1_v <= issue;
            p2_v <= p1_v;
            if (stage_end) stage <= last_stage ? '0 : stage + 4'd1;
            if (p2_v && bf_sat) ovf <= 1'b1;
            if (acc) begin
                cnt <= cnt + addr_t'(1);
                if (cnt == '0) begin
                    inv_r <= mode_inv;
                    scale_r <= mode_scale;
                end
            end
            // the output register doubles as the skid: it reloads only when empty or being consumed
            if (state == UNLOAD) begin
                if (out_hs && out_last) begin
                    out_valid <= 1'b0;
                    out_last <= 1'b0;
                    ovf <= 1'b0;
                end else if (!out_valid || out_ready) begin
                    out_valid <= 1'b1;
                    {out_re, out_im} <= mem[cnt];
                    out_index <= cnt;
                    out_last <= cnt == addr_t'(N - 1);
                    cnt <= cnt + addr_t'(1);
                end
            end
        end
    end
endmodule

// File: doc/fft_iterative.md
# fft_iterative

Sequential, memory-based radix-2 decimation-in-time FFT/IFFT over N complex signed fixed-point samples. It is the resource-shared successor of the fully combinational recursive FFT: one butterfly unit is time-multiplexed over log2(N) stages. Frames stream in and out through valid/ready handshakes. Per-frame mode selects forward or inverse transform and optional per-stage scaling, and a sticky flag reports saturation.

## Interface
- N, 16: points per frame; power of 2, 4..1024.
- WIDTH, 12: sample width (re and im each), signed.
- TW_WIDTH, 16: twiddle width, signed; value = round(cos/sin × (2^(TW_WIDTH-1)−1)).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample.
- in_re, in_im  in  WIDTH each  input sample, natural order.
- mode_inv  in  1  inverse transform (conjugate twiddles); sampled with sample 0.
- mode_scale  in  1  arithmetic >>1 after every stage; sampled with sample 0.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_re, out_im  out  WIDTH each  output bin, natural order.
- out_index  out  log2(N)  bin index of current output.
- out_last  out  1  high with bin N−1.
- busy  out  1  high in COMPUTE and UNLOAD.
- ovf  out  1  some butterfly output saturated in this frame; valid during UNLOAD.

## Operation
- States: LOAD → COMPUTE → UNLOAD → LOAD. Reset enters LOAD with counters at 0.
- LOAD: in_ready=1. A sample is accepted on in_valid&&in_ready and written to RAM at bitrev(count). On accepting sample N−1, go to COMPUTE. There is no frame-length input; exactly N samples form a frame.
- COMPUTE: stages s=0..log2(N)−1. Each stage issues N/2 butterflies, one per cycle. Pair (a, b) has span 2^s; twiddle index k·(N/2^(s+1)), with sign of the imaginary part flipped when mode_inv=1.
- Butterfly arithmetic:
  - t = b×W as full-precision products, +2^(TW_WIDTH-2), then >>> (TW_WIDTH−1).
  - A = a+t, B = a−t, computed at WIDTH+2 bits.
  - If mode_scale=1, >>>1 (floor).
  - Saturate to WIDTH bits. Any saturation sets ovf.
- Results are written in place. Each stage drains its pipeline before the next stage issues, so there are no read-after-write hazards.
- The forward transform is unnormalised. IFFT with mode_scale=1 yields x/N·N = the 1/N-normalised result.
- UNLOAD: reads RAM in natural order. out_valid holds with stable data until out_ready. After the handshake on bin N−1, go to LOAD and clear ovf.
- Load and unload do not overlap: in_ready=0 in COMPUTE and UNLOAD.

## Timing
- Reset values: in_ready=0 during the rst cycle, then 1 in the first cycle after rst falls. out_valid=0, out_last=0, out_index=0, busy=0, ovf=0, out_re/out_im=0.
- The butterfly unit has a 2-cycle latency: RAM read, then register plus write.
- One stage takes N/2+2 cycles. COMPUTE lasts log2(N)·(N/2+2) cycles.
- The first out_valid comes 1 cycle after COMPUTE ends (RAM read latency). With out_ready held high, one bin per cycle follows.
- Backpressure: out_re/out_im/out_index/out_last must not change while out_valid&&!out_ready.
- rst asserted in any state, including mid-stage or mid-unload, aborts the frame. Outputs return to their reset values on the next edge. RAM contents are don't-care.
- in_valid while in_ready=0 is ignored and the data is not captured.

## Structure
- fft_pkg holds:
  - complex_t struct {re, im} parameterised via WIDTH localparam wrapper.
  - function bitrev(idx, LOG2N).
  - state enum {LOAD, COMPUTE, UNLOAD}.
  - twiddle ROM generation function (constant cos/sin tables for N/2 entries).
- Sub-module fft_bfly_core: one pipelined radix-2 butterfly with inputs a, b, W, scale and outputs A, B, sat.
- Top level holds the FSM, address generators, dual-port N×2·WIDTH RAM and output skid.

## Test plan
- N=8, scale off, impulse x[0]=100+0j → all 8 bins = 100+0j, ovf=0, out_last on bin 7.
- N=8, scale on, constant x[n]=64+0j → bin 0 = 64 (64·8/8), bins 1..7 = 0.
- N=16, forward then inverse with scale on, random |x|<256 → reconstructed x within ±2 LSB.
- N=8, scale off, constant x[n]=2047 → bin 0 saturates to 2047, ovf=1; ovf=0 for the next benign frame.
- Unload with out_ready toggling at random (50%) → bins 0..N−1 in order, each held stable, no drops or duplicates; in_ready=0 throughout.
- rst pulsed for 1 cycle mid-COMPUTE (stage 1) → next cycle out_valid=0, busy=0; then in_ready=1 and a fresh impulse frame produces correct output.
